iic_cfg_seq: RTL and testbench
==============================

# iic_cfg_seq

Parametrised I2C configuration sequencer for the HDMI transmitter control bus. It walks a table of NUM_ENTRIES register writes (7-bit device address, register, value) and issues one I2C write per entry on open-drain SDA/SCL. Bus timing is derived from a divider running off the system clock, so there is no generated clock. The block retries NACKed transactions, records failures, and reports completion through status outputs for LED/debug display.

## Interface
- NUM_ENTRIES, 8: table length, ≥1
- CLK_DIV, 250: clk cycles per SCL quarter-period, ≥2
- MAX_RETRY, 3: extra attempts per entry after a NACK
- IDX_W, $clog2(NUM_ENTRIES): table index width, minimum 1

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the sequence at entry 0
- skip_err  in  1  1 = continue after retries are exhausted; 0 = abort
- tbl_idx  out  IDX_W  current table index
- tbl_entry  in  23  {dev[6:0], reg[7:0], val[7:0]}; combinational lookup of tbl_idx
- SDA  inout  1  open-drain; drives 0 or z
- SCL  inout  1  open-drain; drives 0 or z
- busy  out  1  sequence in progress
- done  out  1  level; set at sequence end, cleared by start
- err  out  1  sticky; at least one entry failed
- err_cnt  out  8  number of failed entries, saturating at 255
- err_idx  out  IDX_W  first failing entry
- err_byte  out  2  byte that NACKed in the first failure: 0 = addr, 1 = reg, 2 = val

## Operation
- The divider asserts tick for one cycle every CLK_DIV cycles while busy. Each bus element spans four quarters, q0..q3, and each quarter lasts one tick.
- The FSM has six states:
  - IDLE → START on start.
  - START:
    - q0 SDA=1 SCL=1
    - q1 SDA=0 SCL=1
    - q2 and q3 SDA=0 SCL=0
  - BYTE: 8 bits, MSB first.
    - Bit: q0 SCL=0 with SDA set; q1 and q2 SCL=1; q3 SCL=0.
    - The bytes are {dev,0}, then reg, then val.
  - ACK: 9th bit with SDA released. SDA is sampled on the tick ending q1; a sampled 1 is a NACK.
  - STOP:
    - q0 SDA=0 SCL=0
    - q1 SDA=0 SCL=1
    - q2 and q3 SDA=1 SCL=1
  - NEXT: one clk cycle, then index++ → START, or → IDLE with done=1 after the last entry.
- On NACK, go to STOP immediately with no further bytes.
  - If the retry count < MAX_RETRY, increment it and restart the same entry.
  - Otherwise the entry has failed:
    - err=1 and err_cnt++.
    - err_idx/err_byte are captured on the first failure only.
    - If skip_err=1, go to NEXT; if skip_err=0, go to IDLE with done=1.
- The retry counter clears on every new entry.
- tbl_entry is latched at entry of START; later table changes do not affect the transaction in progress.
- Clock stretching and arbitration are not supported. SCL is never sampled.

## Timing
- Reset values:
  - SDA=z, SCL=z
  - busy=0, done=0, err=0, err_cnt=0, err_idx=0, err_byte=0, tbl_idx=0
  - Divider at 0
- Asserting rst mid-transaction releases both lines on the next edge. No STOP is issued.
- start takes effect the cycle after it is sampled:
  - busy=1, done=0, err/err_cnt/err_idx/err_byte cleared, tbl_idx=0.
  - The first tick arrives CLK_DIV cycles later.
- A successful transaction is 4+27·4+4 = 116 quarters = 116·CLK_DIV cycles, plus 1 NEXT cycle.
- busy falls in the same cycle done rises.
- start while busy is ignored.
- Simultaneous rst and start: rst wins.
- Line outputs are registered, with no combinational path from tbl_entry.

## Structure
- Package iic_pkg holds:
  - state enum {IDLE, START, BYTE, ACK, STOP, NEXT}
  - struct iic_entry_t {dev, reg, val}
  - phase constants Q0..Q3
  - byte-select constants
- Sub-module iic_tick_gen holds the CLK_DIV counter with synchronous clear while not busy, output tick.
- The top level holds the FSM, the bit/byte counters, the shifter and the status registers.

## Test plan
- All entries ACKed (NUM_ENTRIES=2, CLK_DIV=4, slave model, pull-ups):
  - Slave receives (0x39,0x41,0x10) then (0x39,0x98,0x03).
  - done rises 2·(116·4+1)+1 cycles after start.
  - err=0.
- Entry 1 always NACKs the reg byte, MAX_RETRY=2, skip_err=1:
  - 3 attempts on entry 1, each ending in STOP after the reg ACK slot.
  - err=1, err_cnt=1, err_idx=1, err_byte=1.
  - Entry 2 is still written; done=1.
- Same NACK with skip_err=0:
  - Aborts after the 3rd attempt; entry 2 never appears on the bus.
  - done=1, busy=0.
- NACK on the first attempt only: the retry succeeds and err=0.
- rst pulsed during bit 5 of the val byte:
  - Next cycle SDA=SCL=1 (released) and busy=0.
  - A new start resumes from entry 0.
- start pulsed while busy: no effect.
- start after a failed run: err and err_cnt clear, and the full sequence reruns.

Source files
------------

// File: rtl/iic_pkg.sv
// iic_pkg: shared types and constants for the I2C configuration sequencer
package iic_pkg;
  typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, NEXT} state_t;
  typedef struct packed {
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] val;
  } iic_entry_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic [1:0] B_ADDR = 2'd0;
  localparam logic [1:0] B_REG = 2'd1;
  localparam logic [1:0] B_VAL = 2'd2;
endpackage

// File: rtl/iic_tick_gen.sv
// iic_tick_gen: one-cycle tick every CLK_DIV cycles while busy, held cleared otherwise
module iic_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = busy && cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst || !busy || tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/iic_cfg_seq.sv
// iic_cfg_seq: walks a register-write table and issues one I2C write per entry
module iic_cfg_seq
  import iic_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int CLK_DIV = 250,
  parameter int MAX_RETRY = 3,
  parameter int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             skip_err,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [22:0]      tbl_entry,
  inout  wire              SDA,
  inout  wire              SCL,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic [IDX_W-1:0] err_idx,
  output logic [1:0]       err_byte
);
  state_t state;
  iic_entry_t ent;
  logic [1:0] q, bsel;
  logic [2:0] bitn;
  logic [7:0] sh, retry;
  logic ld, nack, tick, last, run, sda_r, scl_r, sda_d, scl_d;
  assign busy = state != IDLE;
  assign run = busy && state != NEXT;
  assign last = tick && q == Q3;
  assign SDA = sda_r ? 1'bz : 1'b0;
  assign SCL = scl_r ? 1'bz : 1'b0;
  iic_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .busy(run), .tick(tick));
  // line levels follow the current state/quarter and are registered one cycle later
  always_comb begin
    sda_d = 1'b1;
    scl_d = 1'b1;
    case (state)
      START: begin sda_d = q == Q0; scl_d = q <= Q1; end
      BYTE: begin sda_d = sh[7]; scl_d = q == Q1 || q == Q2; end
      ACK: scl_d = q == Q1 || q == Q2;
      STOP: begin sda_d = q >= Q2; scl_d = q != Q0; end
      default: ;
    endcase
  end
  // every state spans four quarters, so q wraps back to Q0 on each transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ent <= '0;
      q <= Q0;
      bsel <= B_ADDR;
      bitn <= '0;
      sh <= '0;
      retry <= '0;
      ld <= 1'b0;
      nack <= 1'b0;
      sda_r <= 1'b1;
      scl_r <= 1'b1;
      tbl_idx <= '0;
      done <= 1'b0;
      err <= 1'b0;
      err_cnt <= '0;
      err_idx <= '0;
      err_byte <= '0;
    end else begin
      sda_r <= sda_d;
      scl_r <= scl_d;
      ld <= 1'b0;
      if (ld) ent <= tbl_entry;
      if (tick) q <= q + 2'd1;
      case (state)
        IDLE: if (start) begin
          state <= START;
          ld <= 1'b1;
          tbl_idx <= '0;
          retry <= '0;
          done <= 1'b0;
          err <= 1'b0;
          err_cnt <= '0;
          err_idx <= '0;
          err_byte <= '0;
        end
        START: if (last) begin
          state <= BYTE;
          sh <= {ent.dev, 1'b0};
          bsel <= B_ADDR;
          bitn <= '0;
        end
        BYTE: if (last) begin
          sh <= sh << 1;
          bitn <= bitn + 3'd1;
          if (bitn == 3'd7) state <= ACK;
        end
        ACK: begin
          if (tick && q == Q1) nack <= SDA;
          if (last) begin
            if (nack || bsel == B_VAL) state <= STOP;
            else begin
              state <= BYTE;
              bsel <= bsel + 2'd1;
              sh <= bsel == B_ADDR ? ent.rg : ent.val;
            end
          end
        end
        STOP: if (last) begin
          if (!nack) state <= NEXT;
          else if (int'(retry) < MAX_RETRY) begin
            state <= START;
            retry <= retry + 8'd1;
            ld <= 1'b1;
          end else begin
            err <= 1'b1;
            err_cnt <= err_cnt + {7'd0, err_cnt != 8'hff};
            if (!err) begin
              err_idx <= tbl_idx;
              err_byte <= bsel;
            end
            state <= skip_err ? NEXT : IDLE;
            done <= !skip_err;
          end
        end
        NEXT: if (tbl_idx == IDX_W'(NUM_ENTRIES - 1)) begin
          state <= IDLE;
          done <= 1'b1;
        end else begin
          state <= START;
          tbl_idx <= tbl_idx + 1'b1;
          retry <= '0;
          ld <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iic_cfg_seq.sv
// tb_iic_cfg_seq: randomized tables and NACK plans against a transaction-level model
module tb_iic_cfg_seq;
  localparam int NE = 3, CD = 4, MR = 2;
  logic clk = 0, rst = 1, start = 0, skip_err = 0, slv_clr = 0;
  logic [1:0] tbl_idx, err_idx, err_byte;
  logic [22:0] tbl_entry;
  logic busy, done, err;
  logic [7:0] err_cnt;
  wire sda, scl;
  logic [22:0] tbl [NE];
  int nb [NE];
  int nt [NE];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  assign tbl_entry = tbl[tbl_idx];
  pullup (sda);
  pullup (scl);

  iic_cfg_seq #(.NUM_ENTRIES(NE), .CLK_DIV(CD), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_err(skip_err), .tbl_idx(tbl_idx),
    .tbl_entry(tbl_entry), .SDA(sda), .SCL(scl), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt), .err_idx(err_idx), .err_byte(err_byte));

  // slave: decodes the bus, NACKs byte nb[k] on the first nt[k] attempts at entry k
  logic sda_p = 1, scl_p = 1, ack_drv = 0;
  logic [7:0] sr;
  logic [23:0] cur;
  int bitc = 0, bytec = 0, cur_k = -1, att = 0;
  int seen [NE];
  logic [23:0] log_d [$];
  int log_nb [$];
  assign sda = ack_drv ? 1'b0 : 1'bz;
  always @(negedge clk) begin
    if (slv_clr) foreach (seen[k]) seen[k] = 0;
    if (scl && scl_p && sda_p && !sda) begin
      bitc = 0; bytec = 0; cur = 0; cur_k = -1;
    end else if (scl && scl_p && !sda_p && sda) begin
      log_d.push_back(cur); log_nb.push_back(bytec); bitc = 0;
    end else if (!scl_p && scl) begin
      if (bitc < 8) sr = {sr[6:0], sda};
      bitc++;
    end else if (scl_p && !scl) begin
      if (bitc == 8 && bytec < 3) begin
        cur[23-8*bytec -: 8] = sr;
        if (bytec == 0) begin
          for (int k = 0; k < NE; k++) if (tbl[k][22:16] == sr[7:1]) cur_k = k;
          if (cur_k >= 0) begin att = seen[cur_k]; seen[cur_k]++; end
        end
        ack_drv = !(cur_k < 0 || (att < nt[cur_k] && nb[cur_k] == bytec));
      end else if (bitc >= 9) begin
        ack_drv = 0; bitc = 0; bytec++;
      end
    end
    sda_p = sda; scl_p = scl;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] txn(input int k, input int n);
    logic [23:0] d = {tbl[k][22:16], 1'b0, tbl[k][15:0]};
    return d & ~(24'hffffff >> (8 * n));
  endfunction

  task automatic new_table();
    for (int k = 0; k < NE; k++) begin
      tbl[k] = 23'($urandom);
      for (int j = 0; j < k; j++) if (tbl[j][22:16] == tbl[k][22:16]) begin
        tbl[k][22:16] = tbl[k][22:16] + 7'd1; j = -1;
      end
      nb[k] = 3; nt[k] = 0;
    end
  endtask

  task automatic run(input bit skip, input bit pulse_mid, input string tag);
    logic [23:0] ed [$];
    int enb [$];
    int ecyc = 1, ecnt = 0, eidx = 0, eb = 0, fails, base, cyc;
    bit eerr = 0;
    for (int k = 0; k < NE; k++) begin
      fails = nb[k] < 3 ? (nt[k] < MR + 1 ? nt[k] : MR + 1) : 0;
      for (int a = 0; a < fails; a++) begin
        ed.push_back(txn(k, nb[k] + 1)); enb.push_back(nb[k] + 1);
        ecyc += (8 + 36 * (nb[k] + 1)) * CD;
      end
      if (fails == MR + 1) begin
        if (!eerr) begin eidx = k; eb = nb[k]; end
        eerr = 1; ecnt++;
        if (!skip) break;
        ecyc += 1;
      end else begin
        ed.push_back(txn(k, 3)); enb.push_back(3);
        ecyc += 116 * CD + 1;
      end
    end
    skip_err = skip; slv_clr = 1;
    @(posedge clk); #1 slv_clr = 0;
    base = log_d.size();
    start = 1;
    @(posedge clk); #1 start = 0;
    cyc = 1;
    chk({tag, ".busy_on"}, busy, 1);
    chk({tag, ".done_clr"}, done, 0);
    chk({tag, ".err_clr"}, {err, err_cnt, 2'(err_idx), err_byte}, 0);
    chk({tag, ".idx0"}, tbl_idx, 0);
    while (!done && cyc < ecyc + 50) begin
      start = pulse_mid && cyc == 300;
      @(posedge clk); #1 start = 0;
      cyc++;
    end
    chk({tag, ".cycles"}, cyc, ecyc);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_off"}, busy, 0);
    chk({tag, ".err"}, err, eerr);
    chk({tag, ".err_cnt"}, err_cnt, ecnt);
    chk({tag, ".err_idx"}, err_idx, eidx);
    chk({tag, ".err_byte"}, err_byte, eb);
    chk({tag, ".ntxn"}, log_d.size() - base, ed.size());
    for (int i = 0; i < ed.size() && base + i < log_d.size(); i++) begin
      chk($sformatf("%s.txn%0d", tag, i), log_d[base+i], ed[i]);
      chk($sformatf("%s.nb%0d", tag, i), log_nb[base+i], enb[i]);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst.lines", {sda, scl}, 2'b11);
    chk("rst.status", {busy, done, err, err_cnt, 2'(err_idx), err_byte, 2'(tbl_idx)}, 0);
    new_table();
    run(1, 0, "all_ack");
    nb[1] = 1; nt[1] = 3;
    run(1, 0, "nack_skip");
    run(0, 0, "nack_abort");
    nb[1] = $urandom_range(0, 2); nt[1] = 1;
    run(0, 0, "nack_once");
    new_table();
    run(1, 1, "start_busy");
    // reset during bit 5 of the value byte (quarter 96, SCL low)
    start = 1;
    @(posedge clk); #1 start = 0;
    repeat (96 * CD + 1) @(posedge clk);
    #1 chk("mid.scl_low", scl, 0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("mid.lines", {sda, scl}, 2'b11);
    chk("mid.busy", busy, 0);
    run(1, 0, "after_rst");
    for (int r = 0; r < 4; r++) begin
      new_table();
      for (int k = 0; k < NE; k++) begin nb[k] = $urandom_range(0, 3); nt[k] = $urandom_range(0, 3); end
      run(1'($urandom), 0, $sformatf("rand%0d", r));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
